// File: rtl/spatial_encoder_mc.sv
// spatial_encoder_mc: multi-lane HDC spatial encoder (bind, bundle, tie-break, bitwise majority).
// Optional: define SPATIAL_ENC_OUTBUF_EN to let the next frame accumulate while hvout waits.
module spatial_encoder_mc #(
  parameter int DIM         = 2000,
  parameter int NUM_CHANNEL = 32,
  parameter int LANES       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [LANES*DIM-1:0] im,
  input  logic [LANES*DIM-1:0] projm,
  output logic                 hvout_valid,
  input  logic                 hvout_ready,
  output logic [DIM-1:0]       hvout
);
  localparam int BEATS      = (NUM_CHANNEL + LANES - 1) / LANES;
  localparam int ACC_W      = $clog2(NUM_CHANNEL + 2);
  localparam int PC_W       = $clog2(LANES + 1);
  localparam int BC_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAST_LANES = NUM_CHANNEL - (BEATS - 1) * LANES;
  localparam int LAST_LANE  = (NUM_CHANNEL - 1) % LANES;
  localparam bit EVEN       = (NUM_CHANNEL % 2) == 0;
  localparam int N_EFF      = NUM_CHANNEL + (EVEN ? 1 : 0);
  localparam logic [ACC_W-1:0] THRESH    = ACC_W'(N_EFF >> 1);
  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BEATS - 1);

  typedef enum logic [1:0] {ACCUM, TIE, MAJ, HOLD} state_t;

  state_t                    state, state_nx;
  logic [BC_W-1:0]           beat_cnt;
  logic [LANES-1:0][DIM-1:0] b;
  logic [DIM-1:0]            t;
  logic [DIM-1:0]            maj;
  logic                      din_fire, hvout_fire, last_beat;
  logic                      acc_load, acc_add, tie_add, maj_load;

  assign din_ready  = (state == ACCUM);
  assign din_fire   = din_valid & din_ready;
  assign hvout_fire = hvout_valid & hvout_ready;
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign acc_load   = din_fire & (beat_cnt == '0);
  assign acc_add    = din_fire & (beat_cnt != '0);
  assign tie_add    = EVEN && (state == TIE);

  // Lanes beyond NUM_CHANNEL only exist on the last beat; force them to zero.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic lane_ok;
    assign lane_ok = (k < LAST_LANES) || !last_beat;
    assign b[k]    = (im[k*DIM +: DIM] ^ projm[k*DIM +: DIM]) & {DIM{lane_ok}};
  end

  for (genvar i = 0; i < DIM; i++) begin : g_col
    logic [LANES-1:0] col;
    logic [PC_W-1:0]  pc;
    logic [ACC_W-1:0] acc;

    for (genvar k = 0; k < LANES; k++) begin : g_tr
      assign col[k] = b[k][i];
    end

    always_comb begin
      pc = '0;
      for (int k = 0; k < LANES; k++) pc = pc + PC_W'(col[k]);
    end

    always_ff @(posedge clk) begin
      if (acc_load)     acc <= ACC_W'(pc);
      else if (acc_add) acc <= acc + ACC_W'(pc);
      else if (tie_add) acc <= acc + ACC_W'(t[i]);
    end

    assign maj[i] = (acc > THRESH);
  end

  // Tie vector = b(ch0) ^ b(ch N-1); both may sit in the same beat when BEATS == 1.
  always_ff @(posedge clk) begin
    if (din_fire) begin
      if (beat_cnt == '0) t <= (BEATS == 1) ? (b[0] ^ b[LAST_LANE]) : b[0];
      else if (last_beat) t <= t ^ b[LAST_LANE];
    end
  end

  always_comb begin
    state_nx = state;
    maj_load = 1'b0;
    case (state)
      ACCUM: if (din_fire && last_beat) state_nx = TIE;
      TIE:   state_nx = MAJ;
      MAJ: begin
`ifdef SPATIAL_ENC_OUTBUF_EN
        if (!hvout_valid || hvout_ready) begin
          maj_load = 1'b1;
          state_nx = ACCUM;
        end
`else
        maj_load = 1'b1;
        state_nx = HOLD;
`endif
      end
      HOLD:    if (hvout_fire) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      beat_cnt    <= '0;
      hvout_valid <= 1'b0;
      hvout       <= '0;
    end else begin
      state <= state_nx;
      if (din_fire) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (maj_load) begin
        hvout       <= maj;
        hvout_valid <= 1'b1;
      end else if (hvout_fire) begin
        hvout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/spatial_encoder_mc.md
Name: spatial_encoder_mc

Overview:
- Parametrised multi-lane spatial encoder for HDC sensor fusion.
- Each cycle it XOR-binds up to LANES channel item vectors (im) with their projection vectors (projm), and accumulates per-bit counts over NUM_CHANNEL channels.
- For an even channel count it adds a tie-break vector, then outputs the bitwise-majority hypervector to the temporal encoder.
- It replaces the single-lane encoder where the channel count or throughput requires several channels per beat.

Parameters:
- DIM, 2000, hypervector width in bits.
- NUM_CHANNEL, 32, channels bundled per frame; must be ≥ 2.
- LANES, 4, channels accepted per input beat; 1 ≤ LANES ≤ NUM_CHANNEL.
- BEATS (localparam), ceil(NUM_CHANNEL/LANES), beats per frame.
- ACC_W (localparam), `ceilLog2(NUM_CHANNEL+2), accumulator width per bit.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- din_valid  in  1  input beat valid.
- din_ready  out  1  encoder accepts a beat.
- im  in  LANES*DIM  item vectors; lane k = bits [k*DIM +: DIM], channel = beat*LANES + k.
- projm  in  LANES*DIM  projection vectors, same lane layout as im.
- hvout_valid  out  1  hvout holds a finished frame.
- hvout_ready  in  1  consumer accepts hvout.
- hvout  out  DIM  majority hypervector.

Behaviour:
- Binding: b[k] = im lane k XOR projm lane k. Lanes with channel ≥ NUM_CHANNEL (last beat only) are masked to zero and never affect counts or the tie-break vector.
- States: ACCUM → TIE → MAJ → HOLD → ACCUM.
- ACCUM:
  - din_ready=1.
  - On din_fire, acc[i] += popcount over valid lanes of b[k][i]. The first beat (beat_cnt=0) loads acc rather than adding to it.
  - beat_cnt increments; after beat BEATS-1, go to TIE.
  - Without din_valid, state and acc hold.
- Tie vector t:
  - t = b(channel 0) XOR b(channel NUM_CHANNEL-1).
  - Captured from the beats carrying those channels; when both are in the same beat, it is captured from that single beat.
- TIE (1 cycle): if NUM_CHANNEL is even, acc[i] += t[i]; otherwise acc holds. Next state is MAJ.
- MAJ (1 cycle):
  - N_eff = NUM_CHANNEL + (NUM_CHANNEL even ? 1 : 0).
  - hvout[i] = acc[i] > (N_eff>>1).
  - hvout_valid set; go to HOLD.
- HOLD:
  - din_ready=0; hvout and hvout_valid stable.
  - On hvout_fire: clear hvout_valid, beat_cnt=0, go to ACCUM.
- Latency: hvout_valid rises 2 cycles after the clock edge accepting the last beat.
- Minimum frame period: BEATS+2 cycles, plus at least one HOLD cycle.
- Widths: per-beat popcount is ceilLog2(LANES+1) bits, zero-extended to ACC_W. acc never overflows because its maximum is NUM_CHANNEL+1.
- Reset: valid in any state.
  - state=ACCUM, beat_cnt=0, hvout_valid=0, hvout=0.
  - acc and t are don't-care, because the first beat loads them.
  - A partial frame is discarded.
- hvout_valid and hvout_ready high in the same cycle as MAJ is impossible, since valid is registered.

Optional Feature:
- SPATIAL_ENC_OUTBUF_EN defined: hvout is a separate output register with its own valid flag.
  - After MAJ, state returns to ACCUM immediately and din_ready=1, so the next frame accumulates while hvout waits.
  - MAJ stalls (acc held, no state change) while hvout_valid=1 and hvout_ready=0.
  - If hvout_fire coincides with MAJ, hvout loads the new frame and hvout_valid stays 1.
  - Steady-state throughput: one frame per BEATS+2 cycles.
- SPATIAL_ENC_OUTBUF_EN undefined: behaviour as in the Behaviour section, with HOLD blocking input.

Test Plan:
- Even count, tie-break: DIM=8, NUM_CHANNEL=4, LANES=2, projm=0; beat0 im={0xFF,0x0F}, beat1 im={0x0F,0x00}.
  - Counts are 4 on bits 0–3 and 2 on bits 4–7, with t=0xFF.
  - Required: hvout=0x0F, hvout_valid 2 cycles after beat1.
- Odd count, masked lane: NUM_CHANNEL=3, LANES=2; beat0 {0xAA,0xA0}, beat1 {0x0A, 0xFF in masked lane}.
  - Required: hvout=0xAA; the masked lane has no effect.
- Backpressure: hold hvout_ready=0 for 10 cycles after valid.
  - Required: hvout stable, din_ready=0 (non-OUTBUF); one transfer only when ready rises.
- Input gaps: insert 3 idle din_valid cycles between beats.
  - Required: same hvout as the gapless run; latency measured from the last beat.
- Reset mid-frame: assert rst after beat0, then send a full new frame.
  - Required: hvout_valid=0 after reset; output reflects only the new frame.
- OUTBUF: two back-to-back frames with hvout_ready=1.
  - Required: din_ready stays 1 except during TIE/MAJ; outputs every BEATS+2 cycles, in order.
